// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF types for the core-side result buffer.
// Holds ID/data widths, handshake payloads and the per-ID tracking state.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef enum logic [1:0] {
    FREE,
    ISSUED,
    COMMITTED,
    KILLED
  } id_state_e;

endpackage

// File: rtl/cvxif_result_buffer_if.sv
// Issue/commit/result/writeback bundle of the result buffer.
// slave is the buffer side, master is the core/coprocessor side.
interface cvxif_result_buffer_if;
  import cvxif_pkg::*;

  logic                  issue_accept_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic                  x_commit_valid_i;
  x_commit_t             x_commit_i;
  logic                  x_result_valid_i;
  x_result_t             x_result_i;
  logic                  x_result_ready_o;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  x_result_t             wb_result_o;
  logic [X_ID_WIDTH:0]   outstanding_o;
  logic                  err_o;

  modport slave (
    input  issue_accept_i,
    input  issue_id_i,
    input  x_commit_valid_i,
    input  x_commit_i,
    input  x_result_valid_i,
    input  x_result_i,
    output x_result_ready_o,
    output wb_valid_o,
    input  wb_ready_i,
    output wb_result_o,
    output outstanding_o,
    output err_o
  );

  modport master (
    output issue_accept_i,
    output issue_id_i,
    output x_commit_valid_i,
    output x_commit_i,
    output x_result_valid_i,
    output x_result_i,
    input  x_result_ready_o,
    input  wb_valid_o,
    output wb_ready_i,
    input  wb_result_o,
    input  outstanding_o,
    input  err_o
  );

endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with power-of-two wrapping pointers.
// Optional fall-through bypasses an empty FIFO combinationally.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic [31:0],
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  dtype          mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          none, bypass, do_push, do_pop;

  assign none    = (cnt_q == '0);
  assign bypass  = FALL_THROUGH && none && push_i && pop_i;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = FALL_THROUGH ? (none && !push_i) : none;
  assign data_o  = (FALL_THROUGH && none) ? data_i : mem_q[rd_q];
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !none;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cvxif_result_buffer.sv
// Tracks offloaded IDs from issue to commit/kill and releases
// buffered coprocessor results to writeback only once committed.
module cvxif_result_buffer
  import cvxif_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = X_ID_WIDTH,
  parameter int unsigned DATA_W = X_RFW_WIDTH
) (
  input logic clk_i,
  input logic rst_ni,
  cvxif_result_buffer_if.slave bus
);

  localparam int unsigned SLOTS = 2**ID_W;

  if (ID_W != X_ID_WIDTH || DATA_W != X_RFW_WIDTH ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("cvxif_result_buffer: unsupported parameters");
  end

  id_state_e   state_q [SLOTS];
  id_state_e   state_d [SLOTS];
  id_state_e   head_st, res_st;
  x_result_t   head;
  logic        full, empty, push, pop;
  logic        err_d, err_q, wb_valid;
  logic [ID_W:0] busy, outstanding_q;
  logic [ID_W-1:0] cid, rid, iid;
  logic        kill, cmt_hit;

  assign cid  = bus.x_commit_i.id;
  assign kill = bus.x_commit_i.x_commit_kill;
  assign rid  = bus.x_result_i.id;
  assign iid  = bus.issue_id_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (DEPTH),
    .dtype        (x_result_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (bus.x_result_i),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign head_st = state_q[head.id];
  assign cmt_hit = bus.x_commit_valid_i &&
                   state_q[cid] == ISSUED;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    res_st  = state_q[rid];
    if (!empty) begin
      unique case (head_st)
        COMMITTED: begin
          if (bus.wb_ready_i) begin
            pop              = 1'b1;
            state_d[head.id] = FREE;
          end
        end
        KILLED: begin
          pop              = 1'b1;
          state_d[head.id] = FREE;
        end
        default: ;
      endcase
    end
    if (bus.x_commit_valid_i) begin
      if (cmt_hit) state_d[cid] = kill ? KILLED : COMMITTED;
      else         err_d = 1'b1;
    end
    // a result sees the outcome of a same-cycle commit to its ID
    if (cmt_hit && cid == rid) res_st = kill ? KILLED : COMMITTED;
    if (bus.x_result_valid_i && !full) begin
      unique case (res_st)
        ISSUED, COMMITTED: push = 1'b1;
        KILLED:            state_d[rid] = FREE;
        default:           err_d = 1'b1;
      endcase
    end
    if (bus.issue_accept_i) begin
      if (state_q[iid] != FREE) err_d = 1'b1;
      state_d[iid] = ISSUED;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < SLOTS; i++)
      busy = busy + (ID_W+1)'(state_q[i] != FREE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SLOTS; i++) state_q[i] <= FREE;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      outstanding_q <= busy;
    end
  end

  assign wb_valid             = !empty && head_st == COMMITTED;
  assign bus.wb_valid_o       = wb_valid;
  assign bus.wb_result_o      = wb_valid ? head : '0;
  assign bus.x_result_ready_o = ~full;
  assign bus.outstanding_o    = outstanding_q;
  assign bus.err_o            = err_q;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed bench for cvxif_result_buffer: commit/kill gating,
// backpressure, ordering, error pulses and async reset.
module tb_cvxif_result_buffer;
  import cvxif_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  cvxif_result_buffer_if bus();

  cvxif_result_buffer #(.DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always @(negedge clk) if (bus.err_o === 1'b1) err_cnt++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_accept_i   = 1'b0;
    bus.issue_id_i       = '0;
    bus.x_commit_valid_i = 1'b0;
    bus.x_commit_i       = '0;
    bus.x_result_valid_i = 1'b0;
    bus.x_result_i       = '0;
    bus.wb_ready_i       = 1'b0;
  endtask

  task automatic issue(input logic [X_ID_WIDTH-1:0] id);
    bus.issue_accept_i = 1'b1;
    bus.issue_id_i     = id;
    step();
    bus.issue_accept_i = 1'b0;
  endtask

  task automatic commit(input logic [X_ID_WIDTH-1:0] id, input logic k);
    bus.x_commit_valid_i         = 1'b1;
    bus.x_commit_i.id            = id;
    bus.x_commit_i.x_commit_kill = k;
    step();
    bus.x_commit_valid_i = 1'b0;
  endtask

  task automatic drive_result(input logic [X_ID_WIDTH-1:0] id,
                              input logic [31:0] d);
    bus.x_result_valid_i = 1'b1;
    bus.x_result_i       = '0;
    bus.x_result_i.id    = id;
    bus.x_result_i.data  = d;
    bus.x_result_i.rd    = 5'(id);
    bus.x_result_i.we    = 1'b1;
  endtask

  task automatic result(input logic [X_ID_WIDTH-1:0] id,
                        input logic [31:0] d);
    drive_result(id, d);
    step();
    bus.x_result_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    bus.wb_ready_i = 1'b1;
    step();
    bus.wb_ready_i = 1'b0;
  endtask

  logic [31:0] exp_q [5];
  int          k;
  logic        acc;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check("rst_wb_result", 64'(bus.wb_result_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    check("rst_ready", 64'(bus.x_result_ready_o), 64'd1);
    rst_n = 1'b1;
    step();

    // basic commit then result
    err_cnt = 0;
    issue(3);
    commit(3, 1'b0);
    check("s1_outstanding", 64'(bus.outstanding_o), 64'd1);
    result(3, 32'h15);
    check("s1_wb_valid", 64'(bus.wb_valid_o), 64'd1);
    check("s1_wb_data", 64'(bus.wb_result_o.data), 64'h15);
    check("s1_wb_we", 64'(bus.wb_result_o.we), 64'd1);
    check("s1_wb_id", 64'(bus.wb_result_o.id), 64'd3);
    pop_one();
    check("s1_popped", 64'(bus.wb_valid_o), 64'd0);
    step();
    check("s1_out_zero", 64'(bus.outstanding_o), 64'd0);
    check("s1_no_err", 64'(err_cnt), 64'd0);

    // result before commit, then commit / kill
    issue(5);
    result(5, 32'h7);
    check("s2_wait0", 64'(bus.wb_valid_o), 64'd0);
    step();
    check("s2_wait1", 64'(bus.wb_valid_o), 64'd0);
    commit(5, 1'b0);
    check("s2_release", 64'(bus.wb_valid_o), 64'd1);
    check("s2_data", 64'(bus.wb_result_o.data), 64'h7);
    pop_one();
    issue(5);
    result(5, 32'h8);
    commit(5, 1'b1);
    check("s2_kill_wb", 64'(bus.wb_valid_o), 64'd0);
    step();
    check("s2_kill_wb2", 64'(bus.wb_valid_o), 64'd0);
    step();
    check("s2_kill_out", 64'(bus.outstanding_o), 64'd0);
    check("s2_kill_ready", 64'(bus.x_result_ready_o), 64'd1);
    check("s2_no_err", 64'(err_cnt), 64'd0);

    // backpressure and in-order drain
    for (int i = 1; i <= 4; i++) issue(4'(i));
    issue(6);
    for (int i = 1; i <= 4; i++) commit(4'(i), 1'b0);
    commit(6, 1'b0);
    exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB6};
    for (int i = 0; i < 4; i++) result(4'(i + 1), exp_q[i]);
    check("s3_full_ready", 64'(bus.x_result_ready_o), 64'd0);
    check("s3_head_valid", 64'(bus.wb_valid_o), 64'd1);
    check("s3_head_data", 64'(bus.wb_result_o.data), 64'hA1);
    drive_result(6, 32'hB6);
    step();
    check("s3_still_full", 64'(bus.x_result_ready_o), 64'd0);
    check("s3_head_stable", 64'(bus.wb_result_o.data), 64'hA1);
    bus.wb_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      if (bus.wb_valid_o) begin
        check($sformatf("s3_drain%0d", k),
              64'(bus.wb_result_o.data), 64'(exp_q[k]));
        k++;
      end
      acc = bus.x_result_valid_i && bus.x_result_ready_o;
      step();
      if (acc) bus.x_result_valid_i = 1'b0;
    end
    bus.wb_ready_i = 1'b0;
    check("s3_drain_count", 64'(k), 64'd5);
    check("s3_ready_back", 64'(bus.x_result_ready_o), 64'd1);
    step();
    check("s3_out_zero", 64'(bus.outstanding_o), 64'd0);
    check("s3_no_err", 64'(err_cnt), 64'd0);

    // result on killed ID is dropped silently
    issue(2);
    commit(2, 1'b1);
    result(2, 32'h22);
    check("s4_no_wb", 64'(bus.wb_valid_o), 64'd0);
    check("s4_err", 64'(bus.err_o), 64'd0);
    step();
    check("s4_out_zero", 64'(bus.outstanding_o), 64'd0);
    check("s4_no_err", 64'(err_cnt), 64'd0);

    // protocol errors
    err_cnt = 0;
    result(9, 32'h99);
    check("s5_res_err", 64'(bus.err_o), 64'd1);
    check("s5_res_nowb", 64'(bus.wb_valid_o), 64'd0);
    step();
    check("s5_err_pulse", 64'(bus.err_o), 64'd0);
    check("s5_ready", 64'(bus.x_result_ready_o), 64'd1);
    commit(6, 1'b0);
    check("s5_cmt_err", 64'(bus.err_o), 64'd1);
    issue(7);
    issue(7);
    check("s5_reissue_err", 64'(bus.err_o), 64'd1);
    commit(7, 1'b1);
    result(7, 32'h77);
    step();
    step();
    check("s5_err_count", 64'(err_cnt), 64'd3);
    check("s5_out_zero", 64'(bus.outstanding_o), 64'd0);

    // async reset mid-stream
    err_cnt = 0;
    for (int i = 10; i <= 12; i++) issue(4'(i));
    for (int i = 10; i <= 12; i++) result(4'(i), 32'(i));
    check("s6_pre_out", 64'(bus.outstanding_o), 64'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_wb", 64'(bus.wb_valid_o), 64'd0);
    check("s6_rst_out", 64'(bus.outstanding_o), 64'd0);
    check("s6_rst_ready", 64'(bus.x_result_ready_o), 64'd1);
    check("s6_rst_err", 64'(bus.err_o), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("s6_post_wb", 64'(bus.wb_valid_o), 64'd0);
    check("s6_post_out", 64'(bus.outstanding_o), 64'd0);
    commit(10, 1'b0);
    check("s6_table_clear", 64'(bus.err_o), 64'd1);
    check("s6_post_wb2", 64'(bus.wb_valid_o), 64'd0);
    issue(10);
    commit(10, 1'b0);
    result(10, 32'h5A);
    check("s6_fresh_valid", 64'(bus.wb_valid_o), 64'd1);
    check("s6_fresh_data", 64'(bus.wb_result_o.data), 64'h5A);
    pop_one();
    check("s6_fresh_pop", 64'(bus.wb_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
